// File: rtl/rf_wb_pkg.sv
// rtl/rf_wb_pkg.sv - shared defaults and source encoding for the writeback arbiter
package rf_wb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int DEPTH_DEF  = 2;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - per-source writeback request FIFO with per-entry address visibility
module wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_i,
  input  logic [ADDR_W-1:0]             push_addr_i,
  input  logic [DATA_W-1:0]             push_data_i,
  input  logic                          pop_i,
  output logic [ADDR_W-1:0]             head_addr_o,
  output logic [DATA_W-1:0]             head_data_o,
  output logic [CNT_W-1:0]              count_o,
  output logic                          full_o,
  output logic [DEPTH-1:0]              ent_valid_o,
  output logic [DEPTH-1:0][ADDR_W-1:0]  ent_addr_o
);

  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]             count_q, count_d;

  // Pointer, count and entry-valid next state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (pop_i) begin
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
      valid_d[rd_ptr_q] = 1'b0;
    end
    if (push_i) begin
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      valid_d[wr_ptr_q] = 1'b1;
    end
    if (push_i && !pop_i) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_i && !push_i) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Entry storage; contents are only meaningful where valid_q is set, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_i) begin
      addr_q[wr_ptr_q] <= push_addr_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_addr_o = addr_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];
  assign count_o     = count_q;
  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign ent_valid_o = valid_q;
  assign ent_addr_o  = addr_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - two-source register file writeback arbiter (RF_WB_ROUND_ROBIN_EN selects round-robin)
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [ADDR_W-1:0]     alu_addr,
  input  logic [DATA_W-1:0]     alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  mem_ready,
  output logic                  rg_wrt_en,
  output logic [ADDR_W-1:0]     rg_wrt_addr,
  output logic [DATA_W-1:0]     rg_wrt_data,
  output logic [2**ADDR_W-1:0]  pend_mask
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                         live_q;
  logic                         alu_push, mem_push, alu_pop, mem_pop;
  logic [ADDR_W-1:0]            alu_head_addr, mem_head_addr;
  logic [DATA_W-1:0]            alu_head_data, mem_head_data;
  logic [CNT_W-1:0]             alu_count, mem_count;
  logic                         alu_full, mem_full;
  logic                         alu_nonempty, mem_nonempty;
  logic [DEPTH-1:0]             alu_ent_valid, mem_ent_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] alu_ent_addr, mem_ent_addr;
  logic                         gnt_valid;
  src_e                         gnt_src;
  logic                         wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]            wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]            wr_data_q, wr_data_d;

  // Holds ready low during reset and until the first edge after it is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) live_q <= 1'b0;
    else       live_q <= 1'b1;
  end

  assign alu_ready    = live_q & ~alu_full;
  assign mem_ready    = live_q & ~mem_full;
  // Writes to register 0 are accepted but dropped here, so they never occupy a slot.
  assign alu_push     = alu_valid & alu_ready & (alu_addr != '0);
  assign mem_push     = mem_valid & mem_ready & (mem_addr != '0);
  assign alu_nonempty = (alu_count != '0);
  assign mem_nonempty = (mem_count != '0);

  wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_alu_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (alu_push),
    .push_addr_i (alu_addr),
    .push_data_i (alu_data),
    .pop_i       (alu_pop),
    .head_addr_o (alu_head_addr),
    .head_data_o (alu_head_data),
    .count_o     (alu_count),
    .full_o      (alu_full),
    .ent_valid_o (alu_ent_valid),
    .ent_addr_o  (alu_ent_addr)
  );

  wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_mem_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (mem_push),
    .push_addr_i (mem_addr),
    .push_data_i (mem_data),
    .pop_i       (mem_pop),
    .head_addr_o (mem_head_addr),
    .head_data_o (mem_head_data),
    .count_o     (mem_count),
    .full_o      (mem_full),
    .ent_valid_o (mem_ent_valid),
    .ent_addr_o  (mem_ent_addr)
  );

`ifdef RF_WB_ROUND_ROBIN_EN
  src_e last_grant_q;

  // Remembers which source won most recently so contention alternates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          last_grant_q <= SRC_MEM;
    else if (gnt_valid) last_grant_q <= gnt_src;
  end

  // Round-robin pick: under contention the source that did not win last time goes.
  always_comb begin
    gnt_valid = alu_nonempty | mem_nonempty;
    gnt_src   = SRC_MEM;
    if (alu_nonempty && mem_nonempty) begin
      gnt_src = (last_grant_q == SRC_MEM) ? SRC_ALU : SRC_MEM;
    end else if (alu_nonempty) begin
      gnt_src = SRC_ALU;
    end
  end
`else
  // Fixed priority pick: loads win over ALU results.
  always_comb begin
    gnt_valid = alu_nonempty | mem_nonempty;
    gnt_src   = SRC_MEM;
    if (!mem_nonempty) begin
      gnt_src = SRC_ALU;
    end
  end
`endif

  assign alu_pop = gnt_valid & (gnt_src == SRC_ALU);
  assign mem_pop = gnt_valid & (gnt_src == SRC_MEM);

  // Output stage next state: reloads every cycle, address/data hold when idle.
  always_comb begin
    wr_en_d   = gnt_valid;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (gnt_valid) begin
      wr_addr_d = (gnt_src == SRC_MEM) ? mem_head_addr : alu_head_addr;
      wr_data_d = (gnt_src == SRC_MEM) ? mem_head_data : alu_head_data;
    end
  end

  // Registered drive of the register file write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign rg_wrt_en   = wr_en_q;
  assign rg_wrt_addr = wr_addr_q;
  assign rg_wrt_data = wr_data_q;

  // Scoreboard view: every queued entry plus the in-flight write marks its register busy.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (alu_ent_valid[i]) pend_mask[alu_ent_addr[i]] = 1'b1;
      if (mem_ent_valid[i]) pend_mask[mem_ent_addr[i]] = 1'b1;
    end
    if (wr_en_q) pend_mask[wr_addr_q] = 1'b1;
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - randomized self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DP = 2;
  localparam int NR = 2**AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          alu_valid = 1'b0, mem_valid = 1'b0;
  logic [AW-1:0] alu_addr = '0, mem_addr = '0;
  logic [DW-1:0] alu_data = '0, mem_data = '0;
  logic          alu_ready, mem_ready;
  logic          rg_wrt_en;
  logic [AW-1:0] rg_wrt_addr;
  logic [DW-1:0] rg_wrt_data;
  logic [NR-1:0] pend_mask;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
    .clk         (clk),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_addr    (alu_addr),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .rg_wrt_en   (rg_wrt_en),
    .rg_wrt_addr (rg_wrt_addr),
    .rg_wrt_data (rg_wrt_data),
    .pend_mask   (pend_mask)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one queue per source, a write port image, and who won last.
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           alu_q[$];
  wr_t           mem_q[$];
  bit            m_live;
  bit            m_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  bit            m_last_mem;

  function automatic void model_reset();
    alu_q.delete();
    mem_q.delete();
    m_live     = 1'b0;
    m_en       = 1'b0;
    m_addr     = '0;
    m_data     = '0;
    m_last_mem = 1'b1;
  endfunction

  function automatic bit exp_ready(int n);
    return m_live && (n < DP);
  endfunction

  function automatic logic [NR-1:0] exp_pend();
    logic [NR-1:0] m;
    m = '0;
    foreach (alu_q[i]) m[alu_q[i].a] = 1'b1;
    foreach (mem_q[i]) m[mem_q[i].a] = 1'b1;
    if (m_en) m[m_addr] = 1'b1;
    return m;
  endfunction

  // One clock cycle: called at a negedge, drives inputs, advances model at the posedge, checks at next negedge.
  task automatic step(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input bit mv, input logic [AW-1:0] ma, input logic [DW-1:0] md);
    bit a_acc, m_acc, take_mem, take_alu, both;
    wr_t w;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    #1;
    check("alu_ready", alu_ready, exp_ready(alu_q.size()));
    check("mem_ready", mem_ready, exp_ready(mem_q.size()));
    a_acc = av && exp_ready(alu_q.size());
    m_acc = mv && exp_ready(mem_q.size());
    @(posedge clk);
    both = (alu_q.size() > 0) && (mem_q.size() > 0);
`ifdef RF_WB_ROUND_ROBIN_EN
    take_mem = both ? !m_last_mem : (mem_q.size() > 0);
`else
    take_mem = (mem_q.size() > 0);
`endif
    take_alu = !take_mem && (alu_q.size() > 0);
    if (take_mem) begin
      w = mem_q.pop_front();
      m_en = 1'b1; m_addr = w.a; m_data = w.d; m_last_mem = 1'b1;
    end else if (take_alu) begin
      w = alu_q.pop_front();
      m_en = 1'b1; m_addr = w.a; m_data = w.d; m_last_mem = 1'b0;
    end else begin
      m_en = 1'b0;
    end
    if (a_acc && aa != '0) alu_q.push_back('{a: aa, d: ad});
    if (m_acc && ma != '0) mem_q.push_back('{a: ma, d: md});
    m_live = 1'b1;
    @(negedge clk);
    check("rg_wrt_en", rg_wrt_en, m_en);
    check("rg_wrt_addr", rg_wrt_addr, m_addr);
    check("rg_wrt_data", rg_wrt_data, m_data);
    check("pend_mask", pend_mask, exp_pend());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0);
  endtask

  initial begin
    logic [AW-1:0] ra, rb;
    int mem_sent;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_wrt_en", rg_wrt_en, 1'b0);
    check("rst_wrt_addr", rg_wrt_addr, '0);
    check("rst_wrt_data", rg_wrt_data, '0);
    check("rst_alu_ready", alu_ready, 1'b0);
    check("rst_mem_ready", mem_ready, 1'b0);
    check("rst_pend", pend_mask, '0);
    reset = 1'b0;

    // Ready stays low until the first edge after reset release.
    idle(1);

    // Single ALU write to r5.
    step(1, 5, 32'hDEADBEEF, 0, '0, '0);
    check("single_pend5_q", pend_mask[5], 1'b1);
    check("single_en_early", rg_wrt_en, 1'b0);
    idle(1);
    check("single_en", rg_wrt_en, 1'b1);
    check("single_addr", rg_wrt_addr, 5);
    check("single_data", rg_wrt_data, 32'hDEADBEEF);
    check("single_pend5_out", pend_mask[5], 1'b1);
    idle(1);
    check("single_done_en", rg_wrt_en, 1'b0);
    check("single_done_pend", pend_mask, '0);
    check("single_hold_addr", rg_wrt_addr, 5);

    // Simultaneous ALU r3 and MEM r7.
    step(1, 3, 32'h0000_0333, 1, 7, 32'h0000_0777);
    idle(1);
`ifdef RF_WB_ROUND_ROBIN_EN
    check("contend_first", rg_wrt_addr, 3);
`else
    check("contend_first", rg_wrt_addr, 7);
`endif
    idle(1);
`ifdef RF_WB_ROUND_ROBIN_EN
    check("contend_second", rg_wrt_addr, 7);
`else
    check("contend_second", rg_wrt_addr, 3);
`endif
    idle(2);

    // Write to r0 is swallowed.
    step(1, 0, 32'h0000_1234, 0, '0, '0);
    check("r0_pend", pend_mask, '0);
    idle(1);
    check("r0_en", rg_wrt_en, 1'b0);
    idle(1);

    // Three MEM requests against a streaming ALU; MEM holds each request until accepted.
    mem_sent = 0;
    for (int i = 0; i < 10; i++) begin
      bit mv;
      mv = (mem_sent < 3);
      if (mv && exp_ready(mem_q.size())) begin
        step(1, AW'(8 + i), 32'hA000_0000 + i, 1, AW'(20 + mem_sent), 32'hB000_0000 + mem_sent);
        mem_sent++;
      end else begin
        step(1, AW'(8 + i), 32'hA000_0000 + i, mv, AW'(20 + mem_sent), 32'hB000_0000 + mem_sent);
      end
    end
    check("burst_mem_all_sent", mem_sent, 3);
    idle(8);

    // Fill both queues, then reset mid-cycle.
    for (int i = 0; i < 4; i++) step(1, AW'(1 + i), $urandom, 1, AW'(16 + i), $urandom);
    alu_valid = 1'b0; mem_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_en", rg_wrt_en, 1'b0);
    check("mid_rst_pend", pend_mask, '0);
    check("mid_rst_alu_ready", alu_ready, 1'b0);
    check("mid_rst_mem_ready", mem_ready, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    idle(4);

    // Random traffic, including r0 targets and idle gaps.
    for (int i = 0; i < 400; i++) begin
      ra = AW'($urandom_range(0, NR - 1));
      rb = AW'($urandom_range(0, NR - 1));
      step($urandom_range(0, 9) < 7, ra, $urandom, $urandom_range(0, 9) < 6, rb, $urandom);
    end
    idle(6);

    // Continuous traffic from both sources.
    for (int i = 0; i < 100; i++) begin
      ra = AW'($urandom_range(1, NR - 1));
      rb = AW'($urandom_range(1, NR - 1));
      step(1, ra, 32'hA500_0000 | i, 1, rb, 32'h5A00_0000 | i);
    end
    idle(6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
